bus_arbiter_rr: RTL and testbench

- Parametrised successor to the 3-master shared-resource arbiter.
- Grants exclusive access to one of N_MASTERS masters.
  - Master 0 is the priority master: it may preempt any other owner for a bounded window, then ownership returns to the preempted master.
  - Masters 1..N-1 share access round-robin with a bounded time slice.
- Sits between the master request/done pulses and the shared-resource mux select; the accmodule output drives that select.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/bus_arbiter_rr.sv | 188 ++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter with priority preemption.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIO    = 2'd1,
    GRANT   = 2'd2,
    PREEMPT = 2'd3
  } arb_state_e;

  localparam int ID_NONE = 0;

  // Master index i is reported on the owner bus as i+1; 0 means no owner.
  function automatic int idx_to_id(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector over masters 1..N-1, starting the search at ptr.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  int cand;

  always_comb begin
    cand    = 0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      cand = int'(ptr) + k;
      // Wrap inside 1..N-1; bit 0 is the priority master and never competes here.
      if (cand > N - 1) cand = cand - (N - 1);
      if (!win_vld && req_vec[cand]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared-resource arbiter: master 0 preempts for a bounded window, masters 1..N-1
// share round-robin with a bounded slice. accmodule drives the resource mux select.
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_MASTERS      = 3,
  parameter int SLICE_CYCLES   = 2,
  parameter int PREEMPT_CYCLES = 2,
  parameter int CNT_W          = 16,
  parameter int ID_W           = $clog2(N_MASTERS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] done,
  output logic [ID_W-1:0]      accmodule,
  output logic [N_MASTERS-1:0] grant,
  output logic [N_MASTERS-1:0] pending,
  output logic [CNT_W-1:0]     nb_interrupts,
  output arb_state_e           state_dbg
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int SL_W  = $clog2(SLICE_CYCLES + 1);
  localparam int PR_W  = $clog2(PREEMPT_CYCLES + 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     own_q, own_d;
  logic [ID_W-1:0]      acc_q, acc_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [N_MASTERS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [SL_W-1:0]      slice_q, slice_d;
  logic [PR_W-1:0]      pre_q, pre_d;
  logic                 saved_vld_q, saved_vld_d;
  logic [IDX_W-1:0]     saved_idx_q, saved_idx_d;
  logic [SL_W-1:0]      saved_slice_q, saved_slice_d;
  logic [CNT_W-1:0]     nb_q, nb_d;

  logic                 g_release, p_release, saved_drop, choose;
  logic [N_MASTERS-1:0] saved_mask, eff_req;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_vld;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    if (int'(i) >= N_MASTERS - 1) return IDX_W'(1);
    else return i + IDX_W'(1);
  endfunction

  // Owner and saved master cannot re-queue themselves; everyone else is eligible this edge.
  always_comb begin
    saved_mask = '0;
    if (saved_vld_q) saved_mask[saved_idx_q] = 1'b1;
    eff_req = pending_q | (req & ~(grant_q | saved_mask));
  end

  // Release conditions and pointer advance are resolved first so the picker sees the new pointer.
  always_comb begin
    g_release  = 1'b0;
    p_release  = 1'b0;
    saved_drop = (state_q == PREEMPT) && saved_vld_q && done[saved_idx_q];
    ptr_d      = ptr_q;
    if (state_q == GRANT)
      g_release = done[own_q] || (int'(slice_q) + 1 >= SLICE_CYCLES);
    if (state_q == PREEMPT)
      p_release = done[0] || (int'(pre_q) + 1 >= PREEMPT_CYCLES);
    if (g_release) ptr_d = next_ptr(own_q);
    else if (saved_drop) ptr_d = next_ptr(saved_idx_q);
  end

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_vec (eff_req),
    .ptr     (ptr_d),
    .win_idx (rr_idx),
    .win_vld (rr_vld)
  );

  always_comb begin
    state_d       = state_q;
    own_d         = own_q;
    slice_d       = slice_q;
    pre_d         = pre_q;
    saved_vld_d   = saved_vld_q;
    saved_idx_d   = saved_idx_q;
    saved_slice_d = saved_slice_q;
    nb_d          = nb_q;
    choose        = 1'b0;

    case (state_q)
      IDLE: choose = 1'b1;
      PRIO: if (done[0]) choose = 1'b1;
      GRANT: begin
        // A release (done or expiry) outranks a preemption request in the same cycle.
        if (g_release) begin
          choose = 1'b1;
        end else if (eff_req[0]) begin
          state_d       = PREEMPT;
          own_d         = '0;
          pre_d         = '0;
          saved_vld_d   = 1'b1;
          saved_idx_d   = own_q;
          saved_slice_d = slice_q + SL_W'(1);
          if (!(&nb_q)) nb_d = nb_q + CNT_W'(1);
        end else begin
          slice_d = slice_q + SL_W'(1);
        end
      end
      PREEMPT: begin
        if (saved_drop) saved_vld_d = 1'b0;
        if (p_release) begin
          if (saved_vld_q && !saved_drop) begin
            state_d     = GRANT;
            own_d       = saved_idx_q;
            slice_d     = saved_slice_q;
            saved_vld_d = 1'b0;
          end else begin
            choose = 1'b1;
          end
        end else begin
          pre_d = pre_q + PR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (choose) begin
      if (eff_req[0]) begin
        state_d = PRIO;
        own_d   = '0;
      end else if (rr_vld) begin
        state_d = GRANT;
        own_d   = rr_idx;
        slice_d = '0;
      end else begin
        state_d = IDLE;
        own_d   = '0;
      end
    end

    acc_d   = ID_W'(ID_NONE);
    grant_d = '0;
    if (state_d != IDLE) begin
      acc_d          = ID_W'(idx_to_id(int'(own_d)));
      grant_d[own_d] = 1'b1;
    end
    pending_d = eff_req & ~grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      own_q         <= '0;
      acc_q         <= '0;
      grant_q       <= '0;
      pending_q     <= '0;
      ptr_q         <= IDX_W'(1);
      slice_q       <= '0;
      pre_q         <= '0;
      saved_vld_q   <= 1'b0;
      saved_idx_q   <= '0;
      saved_slice_q <= '0;
      nb_q          <= '0;
    end else begin
      state_q       <= state_d;
      own_q         <= own_d;
      acc_q         <= acc_d;
      grant_q       <= grant_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      slice_q       <= slice_d;
      pre_q         <= pre_d;
      saved_vld_q   <= saved_vld_d;
      saved_idx_q   <= saved_idx_d;
      saved_slice_q <= saved_slice_d;
      nb_q          <= nb_d;
    end
  end

  assign accmodule     = acc_q;
  assign grant         = grant_q;
  assign pending       = pending_q;
  assign nb_interrupts = nb_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (N=3, slice 2, preempt window 2) with an owner scoreboard.
module tb_bus_arbiter_rr;
  import arb_pkg::*;

  localparam int N    = 3;
  localparam int ID_W = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [ID_W-1:0] accmodule;
  logic [N-1:0]    grant;
  logic [N-1:0]    pending;
  logic [15:0]     nb_interrupts;
  arb_state_e      state_dbg;

  logic [ID_W-1:0] exp_q[$];
  int total;
  int bad;

  bus_arbiter_rr #(
    .N_MASTERS      (N),
    .SLICE_CYCLES   (2),
    .PREEMPT_CYCLES (2),
    .CNT_W          (16),
    .ID_W           (ID_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .done          (done),
    .accmodule     (accmodule),
    .grant         (grant),
    .pending       (pending),
    .nb_interrupts (nb_interrupts),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of req/done, push the expected owner, check it after the edge.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input logic [ID_W-1:0] e);
    logic [ID_W-1:0] ex;
    logic [N-1:0]    exg;
    req  = r;
    done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req  = '0;
    done = '0;
    ex   = exp_q.pop_front();
    exg  = '0;
    if (ex != 0) exg[ex-1] = 1'b1;
    chk("accmodule", 32'(accmodule), 32'(ex));
    chk("grant", 32'(grant), 32'(exg));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = '0;
    done  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", 32'(accmodule), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_nb", 32'(nb_interrupts), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_acc", 32'(accmodule), 32'd0);

    // master 0 alone: held 10 cycles until done[0]
    cyc(3'b001, 3'b000, 2'd1);
    chk("prio_state", 32'(state_dbg), 32'(PRIO));
    for (int i = 0; i < 9; i++) cyc(3'b000, 3'b000, 2'd1);
    cyc(3'b000, 3'b001, 2'd0);
    cyc(3'b000, 3'b000, 2'd0);

    // masters 1 and 2 together after reset-state pointer: 2,3,2,3 with re-requests
    cyc(3'b110, 3'b000, 2'd2);
    chk("alt_pending", 32'(pending), 32'b100);
    cyc(3'b000, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd3);
    cyc(3'b010, 3'b000, 2'd3);
    cyc(3'b000, 3'b000, 2'd2);
    cyc(3'b100, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd3);
    cyc(3'b000, 3'b000, 2'd3);
    cyc(3'b000, 3'b000, 2'd0);

    // smooth handover: done[1] with req[2]; done from a non-owner is ignored
    cyc(3'b010, 3'b000, 2'd2);
    cyc(3'b100, 3'b010, 2'd3);
    cyc(3'b000, 3'b010, 2'd3);
    cyc(3'b000, 3'b000, 2'd0);

    // slice expiry of a lone non-priority master
    cyc(3'b010, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd0);
    chk("expiry_state", 32'(state_dbg), 32'(IDLE));

    // preemption of master 1 after one owned cycle, resumed for its remaining cycle
    cyc(3'b010, 3'b000, 2'd2);
    cyc(3'b001, 3'b000, 2'd1);
    chk("pre_state", 32'(state_dbg), 32'(PREEMPT));
    chk("pre_nb", 32'(nb_interrupts), 32'd1);
    cyc(3'b001, 3'b000, 2'd1);
    chk("pre_req0_ignored", 32'(pending), 32'd0);
    cyc(3'b000, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd0);

    // done[1] and req[0] together: release wins, no interrupt counted
    cyc(3'b010, 3'b000, 2'd2);
    cyc(3'b001, 3'b010, 2'd1);
    chk("done_wins_state", 32'(state_dbg), 32'(PRIO));
    chk("done_wins_nb", 32'(nb_interrupts), 32'd1);
    cyc(3'b000, 3'b001, 2'd0);

    // saved master releases while preempted: window end goes idle
    cyc(3'b100, 3'b000, 2'd3);
    cyc(3'b001, 3'b000, 2'd1);
    cyc(3'b000, 3'b100, 2'd1);
    cyc(3'b000, 3'b000, 2'd0);
    chk("drop_nb", 32'(nb_interrupts), 32'd2);
    chk("drop_state", 32'(state_dbg), 32'(IDLE));

    // master 2 preempted, then asynchronous reset mid-window
    cyc(3'b100, 3'b000, 2'd3);
    cyc(3'b001, 3'b000, 2'd1);
    chk("rst2_nb_before", 32'(nb_interrupts), 32'd3);
    cyc(3'b010, 3'b000, 2'd1);
    chk("rst2_pending_before", 32'(pending), 32'b010);
    #2;
    reset = 1'b0;
    #1;
    chk("async_acc", 32'(accmodule), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_pending", 32'(pending), 32'd0);
    chk("async_nb", 32'(nb_interrupts), 32'd0);
    chk("async_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_acc", 32'(accmodule), 32'd0);
    cyc(3'b010, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd2);
    cyc(3'b000, 3'b000, 2'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
